// File: rtl/vx_tl_dmem_sequencer_pkg.sv
// vx_tl_pkg: TileLink-UL opcodes, geometry and the lane/entry records shared by the dmem sequencer
package vx_tl_pkg;
  localparam int NUM_LANES = 4;
  localparam int TAG_WIDTH = 10;
  localparam int NUM_ENTRIES = 16;
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] PUT_FULL = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] ACCESS_ACK = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  typedef logic [31:0] word_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [NUM_LANES-1:0] lmask_t;
  typedef struct packed {
    logic [2:0] opcode;
    logic [29:0] addr;
    logic [3:0] mask;
    word_t data;
  } lane_req_t;
  typedef struct packed {
    logic valid;
    tag_t tag;
    lmask_t exp_mask;
    lmask_t rcvd;
    logic [NUM_LANES-1:0][31:0] data;
  } entry_t;
  function automatic logic [2:0] a_opcode(logic rw, logic [3:0] byteen);
    return !rw ? GET : byteen == 4'hf ? PUT_FULL : PUT_PARTIAL;
  endfunction
endpackage

// File: rtl/vx_tl_dmem_sequencer_if.sv
// vx_tl_dmem_sequencer_if: core dcache req/rsp plus per-lane TL-UL A/D channels; slave = sequencer, master = core/memory side
interface vx_tl_dmem_sequencer_if;
  import vx_tl_pkg::*;
  logic [NUM_LANES-1:0] core_req_valid;
  logic [NUM_LANES-1:0] core_req_rw;
  logic [NUM_LANES-1:0][3:0] core_req_byteen;
  logic [NUM_LANES-1:0][29:0] core_req_addr;
  logic [NUM_LANES-1:0][31:0] core_req_data;
  logic [TAG_WIDTH-1:0] core_req_tag;
  logic [NUM_LANES-1:0] core_req_ready;
  logic [NUM_LANES-1:0] tl_a_valid;
  logic [NUM_LANES-1:0] tl_a_ready;
  logic [NUM_LANES-1:0][2:0] tl_a_opcode;
  logic [NUM_LANES-1:0][3:0] tl_a_size;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0] tl_a_source;
  logic [NUM_LANES-1:0][31:0] tl_a_address;
  logic [NUM_LANES-1:0][3:0] tl_a_mask;
  logic [NUM_LANES-1:0][31:0] tl_a_data;
  logic [NUM_LANES-1:0] tl_d_valid;
  logic [NUM_LANES-1:0][2:0] tl_d_opcode;
  logic [NUM_LANES-1:0][TAG_WIDTH-1:0] tl_d_source;
  logic [NUM_LANES-1:0][31:0] tl_d_data;
  logic [NUM_LANES-1:0] tl_d_ready;
  logic core_rsp_valid;
  logic [NUM_LANES-1:0] core_rsp_tmask;
  logic [NUM_LANES-1:0][31:0] core_rsp_data;
  logic [TAG_WIDTH-1:0] core_rsp_tag;
  logic core_rsp_ready;
  logic err_unexpected;
  modport slave (
    input core_req_valid, core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag,
    input tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_source, tl_d_data, core_rsp_ready,
    output core_req_ready, tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
    output tl_d_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag, err_unexpected
  );
  modport master (
    output core_req_valid, core_req_rw, core_req_byteen, core_req_addr, core_req_data, core_req_tag,
    output tl_a_ready, tl_d_valid, tl_d_opcode, tl_d_source, tl_d_data, core_rsp_ready,
    input core_req_ready, tl_a_valid, tl_a_opcode, tl_a_size, tl_a_source, tl_a_address, tl_a_mask, tl_a_data,
    input tl_d_ready, core_rsp_valid, core_rsp_tmask, core_rsp_data, core_rsp_tag, err_unexpected
  );
endinterface

// File: rtl/vx_tl_dmem_sequencer_rsp_table.sv
// vx_dmem_rsp_table: tag-indexed coalescer entries; ports alloc_* (new read), d_* (per-lane D beats), rsp_* (held core response), busy (entry valid), err (sticky stray beat)
module vx_dmem_rsp_table
  import vx_tl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic alloc,
  input  idx_t alloc_idx,
  input  tag_t alloc_tag,
  input  lmask_t alloc_exp,
  input  lmask_t d_valid,
  input  logic [NUM_LANES-1:0][2:0] d_opcode,
  input  logic [NUM_LANES-1:0][TAG_WIDTH-1:0] d_source,
  input  logic [NUM_LANES-1:0][31:0] d_data,
  input  logic rsp_ready,
  output logic [NUM_ENTRIES-1:0] busy,
  output logic rsp_valid,
  output lmask_t rsp_tmask,
  output logic [NUM_LANES-1:0][31:0] rsp_data,
  output tag_t rsp_tag,
  output logic err
);
  entry_t ent [NUM_ENTRIES];
  entry_t nxt [NUM_ENTRIES];
  idx_t d_idx [NUM_LANES];
  lmask_t hit, miss;
  logic [NUM_ENTRIES-1:0] cand;
  idx_t out_idx, sel;
  logic found, rsp_fire;
  assign rsp_fire = rsp_valid & rsp_ready;
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign d_idx[g] = d_source[g][IDX_W-1:0];
    assign hit[g] = d_valid[g] && d_opcode[g] == ACCESS_ACK_DATA && ent[d_idx[g]].valid &&
                    ent[d_idx[g]].tag == d_source[g] && ent[d_idx[g]].exp_mask[g] && !ent[d_idx[g]].rcvd[g];
    assign miss[g] = d_valid[g] && d_opcode[g] == ACCESS_ACK_DATA && !hit[g];
  end
  for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_busy
    assign busy[e] = ent[e].valid;
  end
  // Completion looks at next-state so the last beat reaches the output register in the same edge.
  always_comb begin
    nxt = ent;
    for (int i = 0; i < NUM_LANES; i++)
      if (hit[i]) begin
        nxt[d_idx[i]].rcvd[i] = 1'b1;
        nxt[d_idx[i]].data[i] = d_data[i];
      end
    if (rsp_fire) nxt[out_idx].valid = 1'b0;
    if (alloc) begin
      nxt[alloc_idx] = '0;
      nxt[alloc_idx].valid = 1'b1;
      nxt[alloc_idx].tag = alloc_tag;
      nxt[alloc_idx].exp_mask = alloc_exp;
    end
  end
  // The entry already sitting in the output register stays valid until it fires, so it is masked out.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_ENTRIES; k++)
      cand[k] = nxt[k].valid && nxt[k].rcvd == nxt[k].exp_mask && !(rsp_valid && idx_t'(k) == out_idx);
    for (int k = NUM_ENTRIES - 1; k >= 0; k--)
      if (cand[k]) begin
        found = 1'b1;
        sel = idx_t'(k);
      end
  end
  always_ff @(posedge clock)
    if (reset) begin
      ent <= '{default: '0};
      rsp_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      ent <= nxt;
      err <= err | |miss;
      if (!rsp_valid || rsp_ready) begin
        rsp_valid <= found;
        out_idx <= sel;
        rsp_tag <= nxt[sel].tag;
        rsp_tmask <= nxt[sel].exp_mask;
        rsp_data <= nxt[sel].data;
      end
    end
endmodule

// File: rtl/vx_tl_dmem_sequencer.sv
// vx_tl_dmem_sequencer: issues Vortex dcache lane requests on per-lane TL-UL A channels and coalesces D beats into one core response per tag; ports clock, reset, bus (slave)
module vx_tl_dmem_sequencer
  import vx_tl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  vx_tl_dmem_sequencer_if.slave bus
);
  lmask_t pending, exp_m;
  lane_req_t a_q [NUM_LANES];
  tag_t src_q;
  logic [NUM_ENTRIES-1:0] busy;
  logic ready, fire, rsp_v;
  idx_t idx;
  assign idx = bus.core_req_tag[IDX_W-1:0];
  assign ready = ~reset & ~|pending & ~busy[idx];
  assign fire = |bus.core_req_valid & ready;
  assign exp_m = bus.core_req_valid & ~bus.core_req_rw;
  assign bus.core_req_ready = {NUM_LANES{ready}};
  assign bus.tl_d_ready = {NUM_LANES{~reset}};
  assign bus.core_rsp_valid = rsp_v & ~reset;
  always_ff @(posedge clock)
    if (reset) pending <= '0;
    else pending <= fire ? bus.core_req_valid : pending & ~bus.tl_a_ready;
  always_ff @(posedge clock)
    if (fire) begin
      src_q <= bus.core_req_tag;
      for (int i = 0; i < NUM_LANES; i++)
        a_q[i] <= '{opcode: a_opcode(bus.core_req_rw[i], bus.core_req_byteen[i]), addr: bus.core_req_addr[i],
                    mask: bus.core_req_byteen[i], data: bus.core_req_data[i]};
    end
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_a
    assign bus.tl_a_valid[g] = pending[g] & ~reset;
    assign bus.tl_a_opcode[g] = a_q[g].opcode;
    assign bus.tl_a_size[g] = 4'd2;
    assign bus.tl_a_source[g] = src_q;
    assign bus.tl_a_address[g] = {a_q[g].addr, 2'b00};
    assign bus.tl_a_mask[g] = a_q[g].mask;
    assign bus.tl_a_data[g] = a_q[g].data;
  end
  vx_dmem_rsp_table u_table (
    .clock(clock),
    .reset(reset),
    .alloc(fire & |exp_m),
    .alloc_idx(idx),
    .alloc_tag(bus.core_req_tag),
    .alloc_exp(exp_m),
    .d_valid(bus.tl_d_valid),
    .d_opcode(bus.tl_d_opcode),
    .d_source(bus.tl_d_source),
    .d_data(bus.tl_d_data),
    .rsp_ready(bus.core_rsp_ready),
    .busy(busy),
    .rsp_valid(rsp_v),
    .rsp_tmask(bus.core_rsp_tmask),
    .rsp_data(bus.core_rsp_data),
    .rsp_tag(bus.core_rsp_tag),
    .err(bus.err_unexpected)
  );
endmodule

// File: tb/tb_vx_tl_dmem_sequencer.sv
// tb_vx_tl_dmem_sequencer: vector table, directed corner sequences and a randomized run against a tag-indexed scoreboard with a TL slave model
module tb_vx_tl_dmem_sequencer;
  import vx_tl_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  vx_tl_dmem_sequencer_if bus();
  vx_tl_dmem_sequencer dut (.clock(clock), .reset(reset), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] rw;
    logic [15:0] be;
    logic [11:0] op;
    logic [3:0] reads;
  } vec_t;
  typedef struct {
    logic [2:0] op;
    logic [31:0] addr;
    logic [3:0] mask;
    logic [31:0] data;
    logic [9:0] src;
  } abeat_t;
  typedef struct {
    logic [2:0] op;
    logic [9:0] src;
    logic [31:0] data;
    int due;
  } dbeat_t;
  vec_t tbl [6];
  abeat_t aq [4][$];
  dbeat_t dq [4][$];
  abeat_t ea;
  dbeat_t db;
  logic exp_v [16];
  logic [9:0] exp_tag [16];
  logic [3:0] exp_m [16];
  logic [127:0] exp_d [16];
  int outstanding = 0;
  logic req_on;
  logic [3:0] rv, rrw;
  logic [15:0] rbe;
  logic [9:0] rtag;
  logic [3:0] rix;
  logic [3:0][29:0] raddr;
  logic [3:0][31:0] rdat;
  logic [11:0] om;
  logic [15:0] bm;
  logic [127:0] ed;
  int fires [4];
  int ord [4];
  int rk, left_a, left_d;
  function automatic logic [31:0] rd_val(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic clr_d;
    bus.tl_d_valid = '0;
    bus.tl_d_opcode = '0;
    bus.tl_d_source = '0;
    bus.tl_d_data = '0;
  endtask
  task automatic clr_inputs;
    bus.core_req_valid = '0;
    bus.core_req_rw = '0;
    bus.core_req_byteen = '0;
    bus.core_req_addr = '0;
    bus.core_req_data = '0;
    bus.core_req_tag = '0;
    bus.tl_a_ready = 4'hf;
    bus.core_rsp_ready = 1'b0;
    clr_d();
  endtask
  task automatic drive_req(logic [3:0] v, logic [3:0] rw, logic [15:0] be, logic [9:0] tag, logic [29:0] base);
    for (int i = 0; i < 4; i++) begin
      bus.core_req_addr[i] = base + 30'(i);
      bus.core_req_data[i] = 32'hD000_0000 | 32'(i);
      bus.core_req_byteen[i] = be[i*4+:4];
    end
    bus.core_req_rw = rw;
    bus.core_req_tag = tag;
    bus.core_req_valid = v;
  endtask
  task automatic d_beat(int l, logic [2:0] op, logic [9:0] src, logic [31:0] d);
    bus.tl_d_valid[l] = 1'b1;
    bus.tl_d_opcode[l] = op;
    bus.tl_d_source[l] = src;
    bus.tl_d_data[l] = d;
  endtask
  initial begin
    tbl[0] = '{4'hf, 4'h0, 16'hffff, 12'h924, 4'hf};
    tbl[1] = '{4'h3, 4'h3, 16'h003f, 12'h008, 4'h0};
    tbl[2] = '{4'h5, 4'h4, 16'h0f00, 12'h004, 4'h1};
    tbl[3] = '{4'h8, 4'h8, 16'h5000, 12'h200, 4'h0};
    tbl[4] = '{4'ha, 4'h0, 16'h0000, 12'h820, 4'ha};
    tbl[5] = '{4'hf, 4'h6, 16'hffff, 12'h804, 4'h9};
    ord = '{2, 0, 3, 1};
    clr_inputs();
    tick();
    tick();
    chk("reset_req_ready", bus.core_req_ready, 4'h0);
    chk("reset_a_valid", bus.tl_a_valid, 4'h0);
    chk("reset_rsp_valid", bus.core_rsp_valid, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_reset_req_ready", bus.core_req_ready, 4'hf);
    chk("post_reset_d_ready", bus.tl_d_ready, 4'hf);
    chk("post_reset_err", bus.err_unexpected, 1'b0);
    // read of 4 lanes, D beats arrive in lane order 2,0,3,1
    drive_req(4'hf, 4'h0, 16'hffff, 10'h005, 30'h100);
    tick();
    bus.core_req_valid = '0;
    chk("t1_a_valid", bus.tl_a_valid, 4'hf);
    chk("t1_a_opcode", bus.tl_a_opcode, 12'h924);
    chk("t1_a_addr0", bus.tl_a_address[0], 32'h0000_0400);
    chk("t1_a_addr3", bus.tl_a_address[3], 32'h0000_040c);
    chk("t1_a_size", bus.tl_a_size, 16'h2222);
    chk("t1_a_source2", bus.tl_a_source[2], 10'h005);
    tick();
    chk("t1_a_done", bus.tl_a_valid, 4'h0);
    for (int k = 0; k < 4; k++) begin
      d_beat(ord[k], ACCESS_ACK_DATA, 10'h005, 32'hAAAA_0000 + 32'(ord[k]));
      tick();
      clr_d();
      if (k == 2) chk("t1_no_early_rsp", bus.core_rsp_valid, 1'b0);
    end
    chk("t1_rsp_valid", bus.core_rsp_valid, 1'b1);
    chk("t1_rsp_tmask", bus.core_rsp_tmask, 4'hf);
    chk("t1_rsp_data", bus.core_rsp_data, 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000);
    chk("t1_rsp_tag", bus.core_rsp_tag, 10'h005);
    bus.core_rsp_ready = 1'b1;
    tick();
    bus.core_rsp_ready = 1'b0;
    chk("t1_rsp_done", bus.core_rsp_valid, 1'b0);
    // opcode / mask / response table
    for (int r = 0; r < 6; r++) begin
      drive_req(tbl[r].valid, tbl[r].rw, tbl[r].be, 10'h040 + 10'(r), 30'h700 + 30'(r * 16));
      #1;
      chk("tv_req_ready", bus.core_req_ready, 4'hf);
      tick();
      bus.core_req_valid = '0;
      om = '0;
      bm = '0;
      ed = '0;
      for (int i = 0; i < 4; i++) begin
        om[i*3+:3] = {3{tbl[r].valid[i]}};
        bm[i*4+:4] = {4{tbl[r].valid[i]}};
        if (tbl[r].reads[i]) ed[i*32+:32] = 32'hC0DE_0000 + 32'(r * 16 + i);
      end
      chk("tv_a_valid", bus.tl_a_valid, tbl[r].valid);
      chk("tv_a_opcode", bus.tl_a_opcode & om, tbl[r].op & om);
      chk("tv_a_mask", bus.tl_a_mask & bm, tbl[r].be & bm);
      tick();
      for (int i = 0; i < 4; i++)
        if (tbl[r].valid[i])
          d_beat(i, tbl[r].rw[i] ? ACCESS_ACK : ACCESS_ACK_DATA, 10'h040 + 10'(r), 32'hC0DE_0000 + 32'(r * 16 + i));
      tick();
      clr_d();
      chk("tv_rsp_valid", bus.core_rsp_valid, |tbl[r].reads);
      if (|tbl[r].reads) begin
        chk("tv_rsp_tmask", bus.core_rsp_tmask, tbl[r].reads);
        chk("tv_rsp_data", bus.core_rsp_data, ed);
      end
      bus.core_rsp_ready = 1'b1;
      tick();
      bus.core_rsp_ready = 1'b0;
    end
    chk("tv_err_clean", bus.err_unexpected, 1'b0);
    // lane 3 A-ready held low for 5 cycles
    drive_req(4'hf, 4'hf, 16'hffff, 10'h030, 30'h600);
    tick();
    bus.core_req_valid = '0;
    bus.tl_a_ready = 4'h7;
    fires = '{0, 0, 0, 0};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t3_req_ready", bus.core_req_ready, 4'h0);
      for (int i = 0; i < 4; i++) if (bus.tl_a_valid[i] && bus.tl_a_ready[i]) fires[i]++;
      tick();
    end
    chk("t3_fires0", fires[0], 1);
    chk("t3_fires1", fires[1], 1);
    chk("t3_fires2", fires[2], 1);
    chk("t3_a_valid", bus.tl_a_valid, 4'h8);
    bus.tl_a_ready = 4'hf;
    tick();
    chk("t3_drained", bus.tl_a_valid, 4'h0);
    chk("t3_ready_back", bus.core_req_ready, 4'hf);
    // index collision: 0x003 waits for 0x013 to leave
    drive_req(4'h1, 4'h0, 16'h000f, 10'h013, 30'h200);
    tick();
    bus.core_req_valid = '0;
    tick();
    drive_req(4'h1, 4'h0, 16'h000f, 10'h003, 30'h300);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall", bus.core_req_ready, 4'h0);
      tick();
    end
    d_beat(0, ACCESS_ACK_DATA, 10'h013, 32'h0000_1313);
    tick();
    clr_d();
    #1;
    chk("t4_stall_rsp", bus.core_req_ready, 4'h0);
    chk("t4_rsp_tag", bus.core_rsp_tag, 10'h013);
    bus.core_rsp_ready = 1'b1;
    tick();
    bus.core_rsp_ready = 1'b0;
    #1;
    chk("t4_release", bus.core_req_ready, 4'hf);
    tick();
    bus.core_req_valid = '0;
    chk("t4_a_source", bus.tl_a_source[0], 10'h003);
    tick();
    d_beat(0, ACCESS_ACK_DATA, 10'h003, 32'h0000_0303);
    tick();
    clr_d();
    chk("t4_rsp2_tag", bus.core_rsp_tag, 10'h003);
    chk("t4_rsp2_data", bus.core_rsp_data, 128'h0000_0303);
    bus.core_rsp_ready = 1'b1;
    tick();
    bus.core_rsp_ready = 1'b0;
    // two tags complete together, consumer back-pressures
    drive_req(4'h1, 4'h0, 16'h000f, 10'h001, 30'h400);
    tick();
    bus.core_req_valid = '0;
    tick();
    drive_req(4'h2, 4'h0, 16'h00f0, 10'h002, 30'h500);
    tick();
    bus.core_req_valid = '0;
    tick();
    d_beat(0, ACCESS_ACK_DATA, 10'h001, 32'h0000_0111);
    d_beat(1, ACCESS_ACK_DATA, 10'h002, 32'h0000_0222);
    tick();
    clr_d();
    for (int c = 0; c < 3; c++) begin
      chk("t5_hold_valid", bus.core_rsp_valid, 1'b1);
      chk("t5_hold_tag", bus.core_rsp_tag, 10'h001);
      chk("t5_hold_data", bus.core_rsp_data, 128'h0000_0111);
      tick();
    end
    bus.core_rsp_ready = 1'b1;
    tick();
    chk("t5_second_valid", bus.core_rsp_valid, 1'b1);
    chk("t5_second_tag", bus.core_rsp_tag, 10'h002);
    chk("t5_second_tmask", bus.core_rsp_tmask, 4'h2);
    chk("t5_second_data", bus.core_rsp_data, {32'h0, 32'h0, 32'h0000_0222, 32'h0});
    tick();
    chk("t5_empty", bus.core_rsp_valid, 1'b0);
    bus.core_rsp_ready = 1'b0;
    // stray AccessAckData
    d_beat(2, ACCESS_ACK_DATA, 10'h007, 32'hDEAD_BEEF);
    tick();
    clr_d();
    chk("t6_err_set", bus.err_unexpected, 1'b1);
    chk("t6_no_rsp", bus.core_rsp_valid, 1'b0);
    tick();
    tick();
    tick();
    chk("t6_err_sticky", bus.err_unexpected, 1'b1);
    reset = 1'b1;
    tick();
    chk("t6_err_cleared", bus.err_unexpected, 1'b0);
    reset = 1'b0;
    clr_inputs();
    // randomized traffic against the scoreboard and TL slave model
    for (int e = 0; e < 16; e++) exp_v[e] = 1'b0;
    req_on = 1'b0;
    tick();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!req_on && cyc < 2500 && $urandom_range(0, 2) != 0) begin
        rv = 4'($urandom_range(1, 15));
        rrw = 4'($urandom);
        rtag = 10'($urandom);
        for (int i = 0; i < 4; i++) begin
          rbe[i*4+:4] = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom);
          raddr[i] = 30'($urandom);
          rdat[i] = $urandom;
        end
        bus.core_req_rw = rrw;
        bus.core_req_tag = rtag;
        bus.core_req_addr = raddr;
        bus.core_req_data = rdat;
        for (int i = 0; i < 4; i++) bus.core_req_byteen[i] = rbe[i*4+:4];
        req_on = 1'b1;
      end
      bus.core_req_valid = req_on ? rv : 4'h0;
      bus.tl_a_ready = cyc < 2500 ? 4'($urandom) : 4'hf;
      bus.core_rsp_ready = cyc < 2500 ? 1'($urandom) : 1'b1;
      clr_d();
      for (int i = 0; i < 4; i++)
        if (dq[i].size() > 0) begin
          rk = $urandom_range(0, dq[i].size() - 1);
          if (dq[i][rk].due <= cyc) begin
            d_beat(i, dq[i][rk].op, dq[i][rk].src, dq[i][rk].data);
            dq[i].delete(rk);
          end
        end
      #1;
      if (req_on && bus.core_req_ready[0]) begin
        for (int i = 0; i < 4; i++)
          if (rv[i]) begin
            ea.op = !rrw[i] ? 3'd4 : (rbe[i*4+:4] == 4'hf) ? 3'd0 : 3'd1;
            ea.addr = {raddr[i], 2'b00};
            ea.mask = rbe[i*4+:4];
            ea.data = rdat[i];
            ea.src = rtag;
            aq[i].push_back(ea);
          end
        if (|(rv & ~rrw)) begin
          rix = rtag[3:0];
          chk("rnd_alloc_idx_free", exp_v[rix], 1'b0);
          exp_v[rix] = 1'b1;
          exp_tag[rix] = rtag;
          exp_m[rix] = rv & ~rrw;
          ed = '0;
          for (int i = 0; i < 4; i++) if (rv[i] && !rrw[i]) ed[i*32+:32] = rd_val({raddr[i], 2'b00});
          exp_d[rix] = ed;
          outstanding++;
        end
        req_on = 1'b0;
      end
      for (int i = 0; i < 4; i++)
        if (bus.tl_a_valid[i] && bus.tl_a_ready[i]) begin
          if (aq[i].size() == 0) chk("rnd_a_unexpected", bus.tl_a_valid[i], 1'b0);
          else begin
            ea = aq[i].pop_front();
            chk("rnd_a_opcode", bus.tl_a_opcode[i], ea.op);
            chk("rnd_a_address", bus.tl_a_address[i], ea.addr);
            chk("rnd_a_mask", bus.tl_a_mask[i], ea.mask);
            chk("rnd_a_source", bus.tl_a_source[i], ea.src);
            if (ea.op != 3'd4) chk("rnd_a_data", bus.tl_a_data[i], ea.data);
          end
          db.op = (bus.tl_a_opcode[i] == 3'd4) ? 3'd1 : 3'd0;
          db.src = bus.tl_a_source[i];
          db.data = rd_val(bus.tl_a_address[i]);
          db.due = cyc + 1 + $urandom_range(0, 8);
          dq[i].push_back(db);
        end
      if (bus.core_rsp_valid && bus.core_rsp_ready) begin
        rix = bus.core_rsp_tag[3:0];
        chk("rnd_rsp_expected", exp_v[rix] && exp_tag[rix] == bus.core_rsp_tag, 1'b1);
        if (exp_v[rix]) begin
          chk("rnd_rsp_tmask", bus.core_rsp_tmask, exp_m[rix]);
          chk("rnd_rsp_data", bus.core_rsp_data, exp_d[rix]);
          exp_v[rix] = 1'b0;
          outstanding--;
        end
      end
      tick();
    end
    left_a = 0;
    left_d = 0;
    for (int i = 0; i < 4; i++) begin
      left_a += aq[i].size();
      left_d += dq[i].size();
    end
    chk("rnd_outstanding", outstanding, 0);
    chk("rnd_a_left", left_a, 0);
    chk("rnd_d_left", left_d, 0);
    chk("rnd_req_left", req_on, 1'b0);
    chk("rnd_err", bus.err_unexpected, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
